l2_class_readout: RTL and testbench
===================================

// Module: l2_class_readout
// PURPOSE
//  Readout stage directly downstream of the L2 layer. Pairs each L2 output spike with the
//  class-label event inside a bounded window, emits a one-hot prediction plus correct/miss
//  flags over a valid/ready handshake, and keeps hit/total counters for accuracy.
//  Neuron k of L2 predicts class k (one-hot, bits 4:1).
// PARAMETERS
//  p_window    32  pairing window in cycles; max wait for the second event after the first (>=2)
//  p_win_width 6   timer width; must satisfy 2**p_win_width > p_window
//  p_cnt_width 16  width of the hit and total counters
// PORTS
//  i_clk         in   1            system clock
//  i_rst_n       in   1            asynchronous active-low reset
//  i_spike       in   4            L2 spike vector, bits 4:1, pulse per cycle
//  i_label       in   4            label event, one-hot, bits 4:1, pulse
//  i_clear       in   1            synchronous clear of counters and overrun flag
//  i_ready       in   1            consumer accepts result when high with o_valid
//  o_valid       out  1            result held stable until accepted
//  o_pred        out  4            predicted class, one-hot; 0 on miss
//  o_correct     out  1            o_pred == latched label, and o_pred != 0
//  o_miss        out  1            label seen but no spike inside the window
//  o_hit_cnt     out  p_cnt_width  accepted results with o_correct=1
//  o_total_cnt   out  p_cnt_width  accepted results
//  o_overrun     out  1            sticky: spike or label dropped while busy
// BEHAVIOUR
//  - Reset: state IDLE, timer 0, latches 0, every output 0.
//  - Spike priority encode: lowest set index wins (4'b0110 -> 4'b0010).
//  - FSM states: IDLE, WAIT_LABEL, WAIT_SPIKE, REPORT.
//  - IDLE:
//    - spike and label in the same cycle: latch both, go to REPORT.
//    - spike only: latch pred, timer=0, go to WAIT_LABEL.
//    - label only: latch label, timer=0, go to WAIT_SPIKE.
//  - WAIT_LABEL:
//    - label arrives: go to REPORT.
//    - timer == p_window-1 with no label: discard, go to IDLE; no count, no output.
//    - further spikes are ignored; they do not set overrun.
//  - WAIT_SPIKE:
//    - spike arrives: go to REPORT.
//    - timer == p_window-1 with no spike: go to REPORT with pred=0, miss=1.
//    - a second label sets o_overrun; the first label is kept.
//  - Timer: increments each cycle in the WAIT states; cleared on entry to a WAIT state.
//  - Event on the final window cycle (timer == p_window-1) still pairs; it takes priority over timeout.
//  - REPORT:
//    - o_valid=1; o_pred, o_correct and o_miss are registered and stable until the handshake.
//    - handshake = o_valid & i_ready: counters update in that cycle, go to IDLE.
//    - o_valid drops the next cycle.
//    - any spike or label seen in REPORT is dropped and sets o_overrun.
//  - Latency: pairing event at cycle T gives o_valid=1 at T+1. With i_ready held high,
//    o_valid is a 1-cycle pulse. No new pairing starts on the handshake cycle; inputs in
//    that cycle are dropped and set overrun.
//  - Counters: on handshake, total += 1 and hit += o_correct. Both saturate at all-ones.
//  - i_clear: zeroes counters and o_overrun. If it coincides with a handshake, the result
//    is 0 (clear wins). It does not alter FSM state or o_valid.
//  - A non-one-hot i_label is treated as given: o_correct needs exact equality.
//  - Reset mid-operation: everything returns to reset values immediately; the pending
//    result is lost.
// TESTING
//  1 Same cycle: spike=4'b0100, label=4'b0100, i_ready=1 -> next cycle o_valid=1,
//    o_pred=4'b0100, o_correct=1; hit=1, total=1.
//  2 Spike 4'b0001 at T, label 4'b0010 at T+5 -> o_valid at T+6, o_correct=0, o_miss=0;
//    hit=0, total=1.
//  3 Label 4'b1000, no spike for 32 cycles -> o_valid, o_pred=0, o_miss=1; total += 1.
//    Spike alone with no label for 32 cycles -> no o_valid, counters unchanged.
//  4 Hold i_ready=0 for 10 cycles in REPORT while pulsing a spike -> outputs stable,
//    o_overrun=1. Then i_ready=1 -> single count, state IDLE.
//  5 Spike 4'b0110 with label 4'b0010 -> o_pred=4'b0010, o_correct=1. Label exactly at
//    timer=p_window-1 -> pairs, o_miss=0.
//  6 Preload counters to all-ones and handshake -> they stay all-ones. Assert i_clear on
//    a handshake cycle -> both 0. Drop i_rst_n in WAIT_SPIKE -> all outputs 0 at once.

Source files
------------

// File: rtl/l2_class_readout.sv
// L2 readout: pairs an L2 spike with a label event inside a bounded window
// and reports a one-hot prediction over valid/ready, with accuracy counters.
module l2_class_readout #(
  parameter int p_window    = 32,
  parameter int p_win_width = 6,
  parameter int p_cnt_width = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [3:0]             i_spike,
  input  logic [3:0]             i_label,
  input  logic                   i_clear,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [3:0]             o_pred,
  output logic                   o_correct,
  output logic                   o_miss,
  output logic [p_cnt_width-1:0] o_hit_cnt,
  output logic [p_cnt_width-1:0] o_total_cnt,
  output logic                   o_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LABEL,
    WAIT_SPIKE,
    REPORT
  } state_t;

  localparam logic [p_win_width-1:0] t_last =
    p_win_width'(p_window - 1);
  localparam logic [p_cnt_width-1:0] cnt_max = '1;

  state_t state_q, state_d;
  logic [p_win_width-1:0] timer_q, timer_d;
  logic [3:0] pred_q, pred_d;
  logic [3:0] label_q, label_d;
  logic [3:0] enc;
  logic spk, lbl, last;
  logic load, miss_d, hs, ovr_set;

  // lowest set index wins
  assign enc  = i_spike & (~i_spike + 4'd1);
  assign spk  = |i_spike;
  assign lbl  = |i_label;
  assign last = (timer_q == t_last);

  assign o_valid = (state_q == REPORT);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pred_d  = pred_q;
    label_d = label_q;
    load    = 1'b0;
    miss_d  = 1'b0;
    hs      = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (spk) pred_d = enc;
        if (lbl) label_d = i_label;
        if (spk && lbl) begin
          load    = 1'b1;
          state_d = REPORT;
        end else if (spk) begin
          state_d = WAIT_LABEL;
        end else if (lbl) begin
          state_d = WAIT_SPIKE;
        end
      end
      WAIT_LABEL: begin
        if (lbl) begin
          label_d = i_label;
          load    = 1'b1;
          state_d = REPORT;
        end else if (last) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_SPIKE: begin
        ovr_set = lbl;
        if (spk) begin
          pred_d  = enc;
          load    = 1'b1;
          state_d = REPORT;
        end else if (last) begin
          pred_d  = '0;
          miss_d  = 1'b1;
          load    = 1'b1;
          state_d = REPORT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REPORT: begin
        ovr_set = spk | lbl;
        if (i_ready) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pred_q    <= '0;
      label_q   <= '0;
      o_pred    <= '0;
      o_correct <= 1'b0;
      o_miss    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pred_q  <= pred_d;
      label_q <= label_d;
      if (load) begin
        o_pred    <= pred_d;
        o_correct <= (pred_d == label_d) && (pred_d != 4'd0);
        o_miss    <= miss_d;
      end else if (hs) begin
        o_pred    <= '0;
        o_correct <= 1'b0;
        o_miss    <= 1'b0;
      end
    end
  end

  // clear wins over a coincident handshake or overrun event
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit_cnt   <= '0;
      o_total_cnt <= '0;
      o_overrun   <= 1'b0;
    end else if (i_clear) begin
      o_hit_cnt   <= '0;
      o_total_cnt <= '0;
      o_overrun   <= 1'b0;
    end else begin
      if (ovr_set) o_overrun <= 1'b1;
      if (hs) begin
        if (o_total_cnt != cnt_max)
          o_total_cnt <= o_total_cnt + 1'b1;
        if (o_correct && o_hit_cnt != cnt_max)
          o_hit_cnt <= o_hit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_class_readout.sv
// Bench for l2_class_readout: table vectors, corner sequences and a
// randomized run against an event-level reference model.
module tb_l2_class_readout;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int SW = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] spike = '0;
  logic [3:0] label = '0;
  logic clear = 1'b0;
  logic ready = 1'b0;

  logic o_valid, o_correct, o_miss, o_overrun;
  logic [3:0] o_pred;
  logic [CW-1:0] o_hit, o_total;

  logic s_valid, s_correct, s_miss, s_overrun;
  logic [3:0] s_pred;
  logic [SW-1:0] s_hit_o, s_total_o;

  always #5 clk = ~clk;

  l2_class_readout #(.p_window(W), .p_win_width(6), .p_cnt_width(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spike(spike), .i_label(label),
    .i_clear(clear), .i_ready(ready), .o_valid(o_valid),
    .o_pred(o_pred), .o_correct(o_correct), .o_miss(o_miss),
    .o_hit_cnt(o_hit), .o_total_cnt(o_total), .o_overrun(o_overrun)
  );

  l2_class_readout #(.p_window(W), .p_win_width(6), .p_cnt_width(SW)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_spike(spike), .i_label(label),
    .i_clear(clear), .i_ready(ready), .o_valid(s_valid),
    .o_pred(s_pred), .o_correct(s_correct), .o_miss(s_miss),
    .o_hit_cnt(s_hit_o), .o_total_cnt(s_total_o), .o_overrun(s_overrun)
  );

  int errors = 0;
  int checks = 0;

  // reference model: event-level view (open pairing, pending result, totals)
  int m_cyc, m_t0, m_open;
  logic [3:0] m_fpred, m_flabel;
  bit r_valid, r_miss, m_ovr;
  logic [3:0] r_pred, r_label;
  int m_hit, m_total, s_hit, s_total;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [3:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 4'd1 << i;
    return r;
  endfunction

  function automatic bit r_correct();
    return r_valid && (r_pred == r_label) && (r_pred != 4'd0);
  endfunction

  function automatic void model_reset();
    m_cyc = 0; m_t0 = 0; m_open = 0;
    m_fpred = 0; m_flabel = 0;
    r_valid = 0; r_miss = 0; r_pred = 0; r_label = 0;
    m_ovr = 0; m_hit = 0; m_total = 0; s_hit = 0; s_total = 0;
  endfunction

  function automatic void report(input logic [3:0] p, input logic [3:0] l,
                                 input bit miss);
    r_valid = 1; r_pred = p; r_label = l; r_miss = miss;
  endfunction

  function automatic void model_step(input logic [3:0] sp, input logic [3:0] lb,
                                     input bit rdy, input bit clr);
    bit ovs;
    int age;
    ovs = 0;
    if (r_valid) begin
      if (sp != 0 || lb != 0) ovs = 1;
      if (rdy) begin
        m_total++;
        if (s_total < SMAX) s_total++;
        if (r_correct()) begin
          m_hit++;
          if (s_hit < SMAX) s_hit++;
        end
        r_valid = 0;
      end
    end else if (m_open == 0) begin
      if (sp != 0 && lb != 0) report(lowest(sp), lb, 0);
      else if (sp != 0) begin m_open = 1; m_t0 = m_cyc; m_fpred = lowest(sp); end
      else if (lb != 0) begin m_open = 2; m_t0 = m_cyc; m_flabel = lb; end
    end else begin
      age = m_cyc - m_t0;
      if (m_open == 1) begin
        if (lb != 0) begin report(m_fpred, lb, 0); m_open = 0; end
        else if (age == W) m_open = 0;
      end else begin
        if (lb != 0) ovs = 1;
        if (sp != 0) begin report(lowest(sp), m_flabel, 0); m_open = 0; end
        else if (age == W) begin report(4'd0, m_flabel, 1); m_open = 0; end
      end
    end
    if (clr) begin
      m_hit = 0; m_total = 0; s_hit = 0; s_total = 0; m_ovr = 0;
    end else if (ovs) m_ovr = 1;
    m_cyc++;
  endfunction

  task automatic check_outputs();
    cmp("valid", int'(o_valid), int'(r_valid));
    cmp("pred", int'(o_pred), r_valid ? int'(r_pred) : 0);
    cmp("correct", int'(o_correct), int'(r_correct()));
    cmp("miss", int'(o_miss), r_valid ? int'(r_miss) : 0);
    cmp("hit", int'(o_hit), m_hit);
    cmp("total", int'(o_total), m_total);
    cmp("overrun", int'(o_overrun), int'(m_ovr));
    cmp("sat_hit", int'(s_hit_o), s_hit);
    cmp("sat_total", int'(s_total_o), s_total);
  endtask

  task automatic tick(input logic [3:0] sp, input logic [3:0] lb,
                      input bit rdy, input bit clr,
                      output bit v, output logic [3:0] p,
                      output bit c, output bit m);
    @(negedge clk);
    v = o_valid; p = o_pred; c = o_correct; m = o_miss;
    check_outputs();
    spike = sp; label = lb; ready = rdy; clear = clr;
    model_step(sp, lb, rdy, clr);
  endtask

  typedef struct {
    int         mode;   // 0 both together, 1 spike first, 2 label first
    logic [3:0] spk;
    logic [3:0] lab;
    int         gap;
    bit         e_valid;
    logic [3:0] e_pred;
    bit         e_corr;
    bit         e_miss;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v, c, m, seen, sc, sm;
    logic [3:0] p, sp_, lb_, spd;
    int tot0;

    vecs[0] = '{0, 4'b0100, 4'b0100, 0,  1, 4'b0100, 1, 0};
    vecs[1] = '{1, 4'b0001, 4'b0010, 5,  1, 4'b0001, 0, 0};
    vecs[2] = '{2, 4'b0000, 4'b1000, 0,  1, 4'b0000, 0, 1};
    vecs[3] = '{1, 4'b0001, 4'b0000, 0,  0, 4'b0000, 0, 0};
    vecs[4] = '{0, 4'b0110, 4'b0010, 0,  1, 4'b0010, 1, 0};
    vecs[5] = '{1, 4'b0100, 4'b0100, 32, 1, 4'b0100, 1, 0};
    vecs[6] = '{2, 4'b1000, 4'b1000, 32, 1, 4'b1000, 1, 0};
    vecs[7] = '{1, 4'b0010, 4'b0110, 3,  1, 4'b0010, 0, 0};
    vecs[8] = '{2, 4'b1100, 4'b0001, 2,  1, 4'b0100, 0, 0};

    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      seen = 0; spd = 0; sc = 0; sm = 0;
      for (int i = 0; i < 46; i++) begin
        sp_ = 0; lb_ = 0;
        if (vecs[k].mode == 0 && i == 0) begin
          sp_ = vecs[k].spk; lb_ = vecs[k].lab;
        end else if (vecs[k].mode == 1) begin
          if (i == 0) sp_ = vecs[k].spk;
          if (i == vecs[k].gap && i > 0) lb_ = vecs[k].lab;
        end else if (vecs[k].mode == 2) begin
          if (i == 0) lb_ = vecs[k].lab;
          if (i == vecs[k].gap && i > 0) sp_ = vecs[k].spk;
        end
        tick(sp_, lb_, 1, 0, v, p, c, m);
        if (v && !seen) begin
          seen = 1; spd = p; sc = c; sm = m;
        end
      end
      cmp($sformatf("vec%0d_valid", k), int'(seen), int'(vecs[k].e_valid));
      if (vecs[k].e_valid) begin
        cmp($sformatf("vec%0d_pred", k), int'(spd), int'(vecs[k].e_pred));
        cmp($sformatf("vec%0d_correct", k), int'(sc), int'(vecs[k].e_corr));
        cmp($sformatf("vec%0d_miss", k), int'(sm), int'(vecs[k].e_miss));
      end
    end

    // back-pressure: hold REPORT while spikes keep arriving
    tick(4'b0010, 4'b0010, 0, 0, v, p, c, m);
    tot0 = m_total;
    for (int i = 0; i < 10; i++) begin
      tick((i % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0000, 0, 0, v, p, c, m);
      cmp("hold_valid", int'(v), 1);
      cmp("hold_pred", int'(p), 4'b0010);
    end
    tick(0, 0, 1, 0, v, p, c, m);
    cmp("hold_overrun", int'(o_overrun), 1);
    tick(0, 0, 1, 0, v, p, c, m);
    cmp("hold_valid_drop", int'(v), 0);
    cmp("hold_single_count", int'(o_total), tot0 + 1);

    // saturation in the narrow instance
    for (int i = 0; i < 10; i++) begin
      tick(4'b0001, 4'b0001, 1, 0, v, p, c, m);
      tick(0, 0, 1, 0, v, p, c, m);
    end
    tick(0, 0, 1, 0, v, p, c, m);
    cmp("sat_hit_max", int'(s_hit_o), SMAX);
    cmp("sat_total_max", int'(s_total_o), SMAX);

    // clear coinciding with a handshake
    tick(4'b1000, 4'b1000, 1, 0, v, p, c, m);
    tick(0, 0, 1, 1, v, p, c, m);
    tick(0, 0, 1, 0, v, p, c, m);
    cmp("clear_hit", int'(o_hit), 0);
    cmp("clear_total", int'(o_total), 0);
    cmp("clear_overrun", int'(o_overrun), 0);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      sp_ = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      lb_ = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if ($urandom_range(0, 3) == 0) lb_ = lowest(lb_);
      tick(sp_, lb_, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0,
           v, p, c, m);
    end
    tick(0, 0, 1, 0, v, p, c, m);
    tick(0, 0, 1, 0, v, p, c, m);

    // asynchronous reset while waiting for a spike
    tick(4'b0001, 4'b0001, 1, 0, v, p, c, m);
    tick(0, 0, 1, 0, v, p, c, m);
    tick(0, 4'b1000, 1, 0, v, p, c, m);
    tick(0, 0, 1, 0, v, p, c, m);
    tick(0, 0, 1, 0, v, p, c, m);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("rst_valid", int'(o_valid), 0);
    cmp("rst_pred", int'(o_pred), 0);
    cmp("rst_hit", int'(o_hit), 0);
    cmp("rst_total", int'(o_total), 0);
    cmp("rst_overrun", int'(o_overrun), 0);
    cmp("rst_miss", int'(o_miss), 0);
    model_reset();
    spike = 0; label = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick(0, 0, 1, 0, v, p, c, m);
    cmp("post_rst_no_result", int'(o_total), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
